approx_prod_accum: RTL
======================

# approx_prod_accum

Streaming accumulator directly downstream of the 8x8 approximate multiplier. It takes the 16-bit products through a valid/ready handshake and sums each burst of products, with the burst end marked by `in_last`. When a burst ends, it presents the sum, the product count and an overflow flag on a registered output handshake. Its main use is the dot-product and error-characterisation paths that consume multiplier output.

## Interface
Parameters:
- `ACC_W`, default 24: accumulator width; legal range 17..32.
- `CNT_W`, default 8: width of the product counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  a product is offered.
- `in_ready`  out  1  block accepts the offered product.
- `in_prod`  in  16  unsigned product from the multiplier.
- `in_last`  in  1  marks the final product of the burst.
- `out_valid`  out  1  result is held.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  ACC_W  burst sum.
- `out_cnt`  out  CNT_W  number of products in the burst, modulo 2^CNT_W.
- `out_ovf`  out  1  the accumulator overflowed during the burst.

## Operation
- Two-state FSM: `ACCUM` and `HOLD`. Reset state is `ACCUM`, with accumulator, counter and overflow flag all cleared.
- `ACCUM` state:
  - `in_ready` = 1.
  - Input handshake (`in_valid & in_ready`): acc <= acc + zero-extended `in_prod`; cnt <= cnt + 1.
  - A carry out of bit ACC_W-1 sets the sticky `ovf`.
- Handshake with `in_last` = 1:
  - The sum including that product, the updated count and the updated `ovf` load into the output registers.
  - The internal acc, cnt and ovf clear.
  - FSM moves to `HOLD`.
- `HOLD` state:
  - `in_ready` = 0; `out_valid` = 1.
  - Outputs stay stable until `out_ready` = 1.
  - On that cycle, `out_valid` falls and the FSM returns to `ACCUM`.
  - No bypass: the next product is accepted at the earliest one cycle after the output handshake.
- Counter wraps modulo 2^CNT_W. Wrap is not flagged.
- A burst of one product (`in_last` on the first handshake) is legal: `out_acc` = that product, `out_cnt` = 1.
- `in_prod` and `in_last` are ignored when `in_valid` = 0.
- Reset mid-burst or in `HOLD` discards all state. Outputs return to reset values immediately, since reset is asynchronous.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_acc` = 0, `out_cnt` = 0, `out_ovf` = 0.
- Throughput: one product per cycle in `ACCUM`.
- Latency: `out_valid` rises in the cycle after the `in_last` handshake.
- Minimum gap between bursts is one cycle (the `HOLD` cycle) when `out_ready` is held at 1.
- `in_ready` is a function of FSM state only. It has no combinational path from `in_valid`.
- `out_valid`, `out_acc`, `out_cnt` and `out_ovf` are all registered outputs.

## Configuration
- `ACC_SAT_EN` defined:
  - On overflow, the accumulator clamps at 2^ACC_W-1 for the rest of the burst.
  - `out_ovf` is still set.
- `ACC_SAT_EN` undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - `out_ovf` is set on the first carry out.

## Structure
- Shared package `approx_mult_pkg`:
  - `PROD_W` = 16.
  - FSM state enum `acc_state_t` with values `ACCUM` and `HOLD`.
  - Default widths `ACC_W_DEF` = 24 and `CNT_W_DEF` = 8.
- One sub-module, `acc_add_sat`:
  - Combinational ACC_W adder taking the zero-extended product.
  - Outputs the sum and carry.
  - The `ACC_SAT_EN` clamp is implemented only inside this sub-module.
- Top level holds the FSM, the counter, and the output registers.

## Test plan
- **Basic burst:** products 100, 200, 300, with `in_last` on 300 and `out_ready` = 1.
  - Next cycle: `out_acc` = 600, `out_cnt` = 3, `out_ovf` = 0.
  - `in_ready` = 0 for exactly one cycle.
- **Single-product burst:** 0xFFFF with `in_last` → `out_acc` = 65535, `out_cnt` = 1.
- **Overflow, ACC_W = 17:** burst 0xFFFF, 0xFFFF, 0x0002.
  - With `ACC_SAT_EN`: `out_acc` = 0x1FFFF, `out_ovf` = 1.
  - Without it: `out_acc` = 0x00000, `out_ovf` = 1.
- **Backpressure:** `out_ready` = 0 for 5 cycles after a result.
  - `out_valid` stays 1 and the outputs stay stable.
  - `in_ready` = 0 and offered products are not consumed.
  - After release, the next burst sums correctly from 0.
- **Reset mid-burst:** accept 2 products, then assert `rst_n` = 0 for 1 cycle.
  - Burst 7 with `in_last` then gives `out_acc` = 7, `out_cnt` = 1.
- **Counter wrap, CNT_W = 2:** 5 products of value 1 → `out_cnt` = 1, `out_acc` = 5.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier datapath consumers:
// product width, default accumulator/counter widths and the accumulator FSM
// state type.
package approx_mult_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/approx_prod_accum_add_sat.sv
// acc_add_sat: combinational ACC_W-bit adder of the running sum and a
// zero-extended 16-bit product. Reports the carry out of the top bit.
// Build option: define ACC_SAT_EN to clamp the sum at all-ones whenever a
// carry occurs; otherwise the sum wraps modulo 2^ACC_W.
module acc_add_sat
    import approx_mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full_s;

    // Widen by one bit so the carry out of the accumulator is visible.
    always_comb begin
        full_s = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry  = full_s[ACC_W];
`ifdef ACC_SAT_EN
        if (full_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = full_s[ACC_W-1:0];
        end
`else
        sum = full_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/approx_prod_accum.sv
// approx_prod_accum: sums bursts of 16-bit products (burst end marked by
// in_last) and presents sum, product count and a sticky overflow flag on a
// registered output handshake. One product per cycle while accumulating; the
// block holds the result for at least one cycle before taking new products.
// Build option: ACC_SAT_EN selects clamping instead of wrapping on overflow
// (the clamp lives in acc_add_sat).
module approx_prod_accum
    import approx_mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    acc_state_t       state_r;
    logic             in_ready_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic [ACC_W-1:0] out_acc_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic             out_ovf_r;

    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic             take_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ovf_next_s;

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (acc_r),
        .prod  (in_prod),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Accept decode and next count/overflow values for an accepted product.
    always_comb begin
        take_s     = in_valid & in_ready_r;
        cnt_next_s = cnt_r + CNT_W'(1'b1);
        ovf_next_s = ovf_r | carry_s;
    end

    // Burst FSM: accumulate products, latch the result on in_last, hold it
    // until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_acc_r   <= '0;
            out_cnt_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (take_s) begin
                        if (in_last) begin
                            out_acc_r   <= sum_s;
                            out_cnt_r   <= cnt_next_s;
                            out_ovf_r   <= ovf_next_s;
                            out_valid_r <= 1'b1;
                            acc_r       <= '0;
                            cnt_r       <= '0;
                            ovf_r       <= 1'b0;
                            in_ready_r  <= 1'b0;
                            state_r     <= HOLD;
                        end else begin
                            acc_r <= sum_s;
                            cnt_r <= cnt_next_s;
                            ovf_r <= ovf_next_s;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ACCUM;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_cnt   = out_cnt_r;
    assign out_ovf   = out_ovf_r;

endmodule
